// File: rtl/pixel_reader_pkg.sv
// Shared video-memory definitions: MCB opcodes, frame geometry,
// FSM states and the pixel-to-word address mapping.
package pixel_reader_pkg;

  localparam logic [2:0] MCB_INSTR_READ  = 3'b001;
  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;

  localparam int FRAME_W = 256;
  localparam int FRAME_H = 192;

  typedef logic [13:0] tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Word-aligned byte offset of the word holding pixel (x,y)
  function automatic logic [29:0] pixel_addr(
    input logic [7:0] x,
    input logic [7:0] y
  );
    return {14'd0, y, x[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/pixel_reader_if.sv
// MCB command + read-port bundle between the
// pixel reader (master) and the memory controller (slave).
interface pixel_reader_if;

  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty;
  logic        cmd_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl,
    output cmd_byte_addr, rd_en,
    input  cmd_empty, cmd_full,
    input  rd_data, rd_full, rd_empty,
    input  rd_count, rd_overflow, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl,
    input  cmd_byte_addr, rd_en,
    output cmd_empty, cmd_full,
    output rd_data, rd_full, rd_empty,
    output rd_count, rd_overflow, rd_error
  );

endinterface

// File: rtl/pixel_reader.sv
// Single-pixel read-back from the frame buffer over an MCB
// read port, with a one-word cache for horizontal neighbours.
module pixel_reader
  import pixel_reader_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR      = 30'h0,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_screen_done,
  input  logic           pixel_req,
  input  logic [7:0]     pixel_x,
  input  logic [7:0]     pixel_y,
  input  logic           invalidate,
  output logic [7:0]     pixel_rgb,
  output logic           pixel_rd_done,
  output logic           pixel_rd_busy,
  output logic           pixel_rd_error,
  pixel_reader_if.master mem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state;
  logic [29:0] addr;
  tag_t        cur_tag;
  logic [1:0]  lane;
  logic [CW-1:0] cnt;
  logic        timed_out;
  logic        stale;

  logic [31:0] cache_word;
  tag_t        cache_tag;
  logic        cache_valid;

  tag_t req_tag;
  logic hit;
  logic accept;
  logic unused;

  assign req_tag = {pixel_y, pixel_x[7:2]};
  assign hit     = cache_valid & (cache_tag == req_tag)
                 & ~invalidate;
  assign accept  = (state == ST_IDLE) & ~pixel_rd_busy
                 & pixel_req & clear_screen_done;

  assign mem.cmd_instr     = MCB_INSTR_READ;
  assign mem.cmd_bl        = 6'd0;
  assign mem.cmd_byte_addr = addr;
  assign mem.cmd_en = (state == ST_CMD) & ~mem.cmd_full;
  // IDLE pops too, draining words left by timeouts or resets
  assign mem.rd_en  = ((state == ST_IDLE) | (state == ST_WAIT))
                    & ~mem.rd_empty;

  assign unused = ^{mem.cmd_empty, mem.rd_full, mem.rd_count};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      addr           <= '0;
      cur_tag        <= '0;
      lane           <= '0;
      cnt            <= '0;
      timed_out      <= 1'b0;
      stale          <= 1'b0;
      cache_word     <= '0;
      cache_tag      <= '0;
      cache_valid    <= 1'b0;
      pixel_rgb      <= '0;
      pixel_rd_done  <= 1'b0;
      pixel_rd_busy  <= 1'b0;
      pixel_rd_error <= 1'b0;
    end else begin
      if (mem.rd_error | mem.rd_overflow)
        pixel_rd_error <= 1'b1;
      if (invalidate)
        cache_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          pixel_rd_done <= 1'b0;
          pixel_rd_busy <= 1'b0;
          stale         <= 1'b0;
          if (accept) begin
            pixel_rd_busy <= 1'b1;
            cur_tag       <= req_tag;
            lane          <= pixel_x[1:0];
            addr          <= BASE_ADDR
                           + pixel_addr(pixel_x, pixel_y);
            timed_out     <= 1'b0;
            state         <= hit ? ST_DONE : ST_CMD;
          end
        end
        ST_CMD: begin
          stale <= stale | invalidate;
          cnt   <= '0;
          if (!mem.cmd_full)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          stale <= stale | invalidate;
          if (!mem.rd_empty) begin
            // a write seen since issue makes this word stale
            cache_word  <= mem.rd_data;
            cache_tag   <= cur_tag;
            cache_valid <= ~(stale | invalidate);
            state       <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
            pixel_rd_error <= 1'b1;
            timed_out      <= 1'b1;
            state          <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          pixel_rgb     <= timed_out ? 8'h00
                         : cache_word[{lane, 3'b000} +: 8];
          pixel_rd_done <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_reader.sv
// Directed bench for pixel_reader with a small MCB
// read-port responder model.
module tb_pixel_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       csd = 1'b1;
  logic       req = 1'b0;
  logic [7:0] px = '0;
  logic [7:0] py = '0;
  logic       inval = 1'b0;
  logic [7:0] rgb;
  logic       done;
  logic       busy;
  logic       err;

  logic        cmd_full = 1'b0;
  logic        rd_err = 1'b0;
  logic        rd_ovf = 1'b0;
  logic        rd_empty = 1'b1;
  logic [31:0] rd_data = '0;

  int          resp_delay = 3;
  logic [31:0] resp_word = '0;
  int          cd = 0;
  int          cmd_cnt = 0;
  int          pop_cnt = 0;
  logic [29:0] last_addr = '0;
  logic [2:0]  last_instr = '0;
  logic [5:0]  last_bl = '1;

  int checks = 0;
  int errors = 0;

  pixel_reader_if mem();

  assign mem.cmd_empty   = 1'b1;
  assign mem.cmd_full    = cmd_full;
  assign mem.rd_data     = rd_data;
  assign mem.rd_full     = 1'b0;
  assign mem.rd_empty    = rd_empty;
  assign mem.rd_count    = {6'd0, ~rd_empty};
  assign mem.rd_overflow = rd_ovf;
  assign mem.rd_error    = rd_err;

  pixel_reader #(
    .BASE_ADDR(30'h0),
    .TIMEOUT_CYCLES(1023)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear_screen_done(csd),
    .pixel_req(req),
    .pixel_x(px),
    .pixel_y(py),
    .invalidate(inval),
    .pixel_rgb(rgb),
    .pixel_rd_done(done),
    .pixel_rd_busy(busy),
    .pixel_rd_error(err),
    .mem(mem)
  );

  always #5 clk = ~clk;

  // One outstanding word, delivered resp_delay cycles after cmd
  always @(posedge clk) begin
    if (mem.rd_en && !rd_empty) begin
      rd_empty <= 1'b1;
      pop_cnt  <= pop_cnt + 1;
    end
    if (mem.cmd_en) begin
      cmd_cnt    <= cmd_cnt + 1;
      last_addr  <= mem.cmd_byte_addr;
      last_instr <= mem.cmd_instr;
      last_bl    <= mem.cmd_bl;
      cd         <= resp_delay;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        rd_empty <= 1'b0;
        rd_data  <= resp_word;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic request(input logic [7:0] x,
                         input logic [7:0] y);
    px  = x;
    py  = y;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({rgb, done, busy, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rgb, done, busy, err});
    end
    checks++;
    if ({mem.cmd_en, mem.rd_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mem got=%b exp=00",
               {mem.cmd_en, mem.rd_en});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    bit ok;
    int c0;
    c0 = cmd_cnt;
    resp_delay = 3;
    resp_word = 32'hDDCCBBAA;
    request(8'd10, 8'd20);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL miss_busy got=%b exp=1", busy);
    end
    wait_done(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL miss_done got=timeout exp=done");
    end
    checks++;
    if (rgb !== 8'hCC) begin
      errors++;
      $display("FAIL miss_rgb got=%h exp=cc", rgb);
    end
    checks++;
    if (cmd_cnt - c0 != 1 || last_addr !== 30'h1408) begin
      errors++;
      $display("FAIL miss_cmd got=%0d/%h exp=1/1408",
               cmd_cnt - c0, last_addr);
    end
    checks++;
    if (last_instr !== 3'b001 || last_bl !== 6'd0) begin
      errors++;
      $display("FAIL miss_instr got=%b/%0d exp=001/0",
               last_instr, last_bl);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL done_busy got=%b exp=1", busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL after_done got=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_hit();
    int c0;
    c0 = cmd_cnt;
    request(8'd11, 8'd20);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL hit_early got=%b exp=0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || rgb !== 8'hDD) begin
      errors++;
      $display("FAIL hit_done got=%b/%h exp=1/dd", done, rgb);
    end
    checks++;
    if (cmd_cnt != c0) begin
      errors++;
      $display("FAIL hit_nocmd got=%0d exp=%0d", cmd_cnt, c0);
    end
    tick();
  endtask

  task automatic test_invalidate();
    bit ok;
    int c0;
    c0 = cmd_cnt;
    inval = 1'b1;
    tick();
    inval = 1'b0;
    resp_word = 32'h44332211;
    request(8'd11, 8'd20);
    wait_done(50, ok);
    checks++;
    if (!ok || rgb !== 8'h44) begin
      errors++;
      $display("FAIL inval_rgb got=%b/%h exp=1/44", ok, rgb);
    end
    checks++;
    if (cmd_cnt - c0 != 1) begin
      errors++;
      $display("FAIL inval_cmd got=%0d exp=1", cmd_cnt - c0);
    end
    tick();
  endtask

  task automatic test_cmd_full();
    bit ok;
    bit seen;
    int c0;
    c0 = cmd_cnt;
    seen = 1'b0;
    cmd_full = 1'b1;
    resp_word = 32'h12345678;
    request(8'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      if (mem.cmd_en) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen || cmd_cnt != c0) begin
      errors++;
      $display("FAIL full_stall got=%b/%0d exp=0/0",
               seen, cmd_cnt - c0);
    end
    cmd_full = 1'b0;
    #1;
    checks++;
    if (mem.cmd_en !== 1'b1) begin
      errors++;
      $display("FAIL full_release got=%b exp=1", mem.cmd_en);
    end
    wait_done(50, ok);
    checks++;
    if (!ok || rgb !== 8'h78 || cmd_cnt - c0 != 1) begin
      errors++;
      $display("FAIL full_done got=%b/%h/%0d exp=1/78/1",
               ok, rgb, cmd_cnt - c0);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    int p0;
    resp_delay = 1100;
    resp_word = 32'hFFFFFFFF;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL pre_timeout_err got=%b exp=0", err);
    end
    request(8'd100, 8'd5);
    p0 = pop_cnt;
    wait_done(1200, ok);
    checks++;
    if (!ok || err !== 1'b1 || rgb !== 8'h00) begin
      errors++;
      $display("FAIL timeout got=%b/%b/%h exp=1/1/00",
               ok, err, rgb);
    end
    checks++;
    if (last_addr !== 30'h564) begin
      errors++;
      $display("FAIL timeout_addr got=%h exp=564", last_addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pop_cnt != p0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    checks++;
    if (!ok || rd_empty !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_flush got=%b/%b/%b exp=1/1/0",
               ok, rd_empty, busy);
    end
  endtask

  task automatic test_boot();
    int c0;
    bit seen;
    c0 = cmd_cnt;
    seen = 1'b0;
    csd = 1'b0;
    px = 8'd50;
    py = 8'd60;
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy || done) seen = 1'b1;
    end
    req = 1'b0;
    csd = 1'b1;
    checks++;
    if (seen || cmd_cnt != c0) begin
      errors++;
      $display("FAIL boot_ignore got=%b/%0d exp=0/0",
               seen, cmd_cnt - c0);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    bit seen;
    int c0;
    int p0;
    c0 = cmd_cnt;
    resp_delay = 20;
    resp_word = 32'hA5A5A5A5;
    request(8'd200, 8'd100);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_cnt != c0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
    p0 = pop_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if (!ok || {rgb, done, busy, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_wait got=%b/%h exp=1/0",
               ok, {rgb, done, busy, err});
    end
    tick();
    reset = 1'b0;
    ok = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
      if (pop_cnt != p0) ok = 1'b1;
    end
    checks++;
    if (!ok || seen) begin
      errors++;
      $display("FAIL reset_flush got=%b/%b exp=1/0", ok, seen);
    end
  endtask

  task automatic test_rd_error();
    rd_err = 1'b1;
    tick();
    rd_err = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL rd_error_sticky got=%b exp=1", err);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_invalidate();
    test_cmd_full();
    test_timeout();
    test_boot();
    test_reset_in_wait();
    test_rd_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
